gemm_tile_sequencer: RTL and testbench

Parametrised control sequencer for the block-tiled GEMM accelerator. It walks the M/N/K block loops and drives the SRAM A/B read addresses with per-matrix base offsets. It also drives the mesh operand-valid and accumulator-clear strobes, aligned to a configurable SRAM read latency and mesh drain depth, and writes each finished C tile to SRAM C. Unlike the fixed-layout controller, it adds base-address relocation, latency/drain parametrisation, zero-size error reporting and address wrap-around.

---
 rtl/gemm_pkg.sv | 19 +
 rtl/gemm_tile_sequencer_if.sv | 38 +++
 rtl/gemm_valid_delay.sv | 30 +++
 rtl/gemm_tile_sequencer.sv | 159 +++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_pkg.sv
// Shared types for the GEMM tile sequencer: FSM state encoding and the
// width helper for the post-issue drain counter.
// Imported by the sequencer top; no logic of its own.
package gemm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Counter must hold 0 .. rl+dc-1; never narrower than one bit.
  function automatic int drain_cnt_width(input int rl, input int dc);
    return (rl + dc > 1) ? $clog2(rl + dc) : 1;
  endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Control/address bundle between the tile sequencer and its environment.
// The slave modport is the sequencer side; master is the driving side.
// Pure wiring, no timing of its own.
interface gemm_tile_sequencer_if #(
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8
);

  logic                     start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [AddrWidth-1:0]     a_base_i;
  logic [AddrWidth-1:0]     b_base_i;
  logic [AddrWidth-1:0]     c_base_i;
  logic [AddrWidth-1:0]     sram_a_addr_o;
  logic [AddrWidth-1:0]     sram_b_addr_o;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic                     sram_c_we_o;
  logic                     mac_valid_o;
  logic                     mac_clear_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;

  modport master (
    output start_i, M_size_i, K_size_i, N_size_i, a_base_i, b_base_i, c_base_i,
    input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
           mac_valid_o, mac_clear_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, M_size_i, K_size_i, N_size_i, a_base_i, b_base_i, c_base_i,
    output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
           mac_valid_o, mac_clear_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/gemm_valid_delay.sv
// Aligns the {valid, clear} issue flags with SRAM read data.
// Latency: exactly Depth cycles. No backpressure; flags shift every cycle.
module gemm_valid_delay #(
  parameter int Depth = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_valid,
  input  logic i_clear,
  output logic o_valid,
  output logic o_clear
);

  // Each stage holds {valid, clear}.
  logic [1:0] r_sr [Depth];

  // Shift chain, cleared by reset so no stale operand strobes survive an abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) r_sr[i] <= 2'b00;
    end else begin
      r_sr[0] <= {i_valid, i_clear};
      for (int i = 1; i < Depth; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_valid = r_sr[Depth-1][1];
  assign o_clear = r_sr[Depth-1][0];

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks M/N/K block loops for the tiled GEMM mesh, driving A/B reads and C writes.
// Per tile: K issue + ReadLatency+DrainCycles drain + 1 write cycle; done one cycle after last write.
// No backpressure: start is only honoured in IDLE, everything else free-runs.
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8,
  parameter int ReadLatency   = 1,
  parameter int DrainCycles   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gemm_tile_sequencer_if.slave ctl
);

  localparam int DrainW = drain_cnt_width(ReadLatency, DrainCycles);
  localparam logic [DrainW-1:0]        DrainLast = DrainW'(ReadLatency + DrainCycles - 1);
  localparam logic [SizeAddrWidth-1:0] SizeOne   = 1;
  localparam logic [AddrWidth-1:0]     AddrOne   = 1;

  state_e r_state, w_next_state;

  logic [SizeAddrWidth-1:0] r_m_size, r_k_size, r_n_size;
  logic [SizeAddrWidth-1:0] r_m, r_n, r_k;
  logic [AddrWidth-1:0]     r_b_base;
  logic [AddrWidth-1:0]     r_a_row;   // a_base + m*K, maintained by addition
  logic [AddrWidth-1:0]     r_b_row;   // b_base + n*K, maintained by addition
  logic [AddrWidth-1:0]     r_c_addr;  // c_base + m*N + n; tiles are written in linear order
  logic [DrainW-1:0]        r_drain;
  logic                     r_err;

  logic                 w_zero_size, w_k_last, w_drain_last, w_last_tile;
  logic [AddrWidth-1:0] w_k_step;
  logic                 w_issue, w_first_k, w_we, w_busy, w_done;
  logic                 w_mac_valid, w_mac_clear;

  assign w_zero_size  = (ctl.M_size_i == '0) || (ctl.K_size_i == '0) || (ctl.N_size_i == '0);
  assign w_k_last     = (r_k == r_k_size - SizeOne);
  assign w_drain_last = (r_drain == DrainLast);
  assign w_last_tile  = (r_m == r_m_size - SizeOne) && (r_n == r_n_size - SizeOne);
  assign w_k_step     = AddrWidth'(r_k_size);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; a zero-size start never leaves IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (ctl.start_i && !w_zero_size) w_next_state = ST_ISSUE;
      ST_ISSUE: if (w_k_last)                    w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_drain_last)                w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = w_last_tile ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Loop counters, running row offsets and the zero-size error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_size <= '0;
      r_k_size <= '0;
      r_n_size <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_b_base <= '0;
      r_a_row  <= '0;
      r_b_row  <= '0;
      r_c_addr <= '0;
      r_drain  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ctl.start_i) begin
            r_m_size <= ctl.M_size_i;
            r_k_size <= ctl.K_size_i;
            r_n_size <= ctl.N_size_i;
            r_b_base <= ctl.b_base_i;
            r_a_row  <= ctl.a_base_i;
            r_b_row  <= ctl.b_base_i;
            r_c_addr <= ctl.c_base_i;
            r_m      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_err    <= w_zero_size;
          end
        end
        ST_ISSUE: begin
          // k stops at K-1 so the addresses hold through DRAIN.
          if (!w_k_last) r_k <= r_k + SizeOne;
          r_drain <= '0;
        end
        ST_DRAIN: r_drain <= r_drain + 1'b1;
        ST_WRITE: begin
          r_k      <= '0;
          r_c_addr <= r_c_addr + AddrOne;
          if (r_n == r_n_size - SizeOne) begin
            r_n     <= '0;
            r_b_row <= r_b_base;
            r_m     <= r_m + SizeOne;
            r_a_row <= r_a_row + w_k_step;
          end else begin
            r_n     <= r_n + SizeOne;
            r_b_row <= r_b_row + w_k_step;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs plus the registered error pulse, which doubles as done.
  always_comb begin
    w_issue   = 1'b0;
    w_first_k = 1'b0;
    w_we      = 1'b0;
    w_busy    = (r_state != ST_IDLE);
    w_done    = r_err;
    case (r_state)
      ST_ISSUE: begin
        w_issue   = 1'b1;
        w_first_k = (r_k == '0);
      end
      ST_WRITE: w_we   = 1'b1;
      ST_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  gemm_valid_delay #(
    .Depth (ReadLatency)
  ) u_valid_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_valid (w_issue),
    .i_clear (w_first_k),
    .o_valid (w_mac_valid),
    .o_clear (w_mac_clear)
  );

  assign ctl.sram_a_addr_o = r_a_row + AddrWidth'(r_k);
  assign ctl.sram_b_addr_o = r_b_row + AddrWidth'(r_k);
  assign ctl.sram_c_addr_o = r_c_addr;
  assign ctl.sram_c_we_o   = w_we;
  assign ctl.mac_valid_o   = w_mac_valid;
  assign ctl.mac_clear_o   = w_mac_clear;
  assign ctl.busy_o        = w_busy;
  assign ctl.done_o        = w_done;
  assign ctl.err_o         = r_err;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: cycle timing, address streams,
// zero-size rejection, wrap-around, held start and mid-run reset.
module tb_gemm_tile_sequencer;

  localparam int AW   = 12;
  localparam int SW   = 8;
  localparam int RL   = 1;   // the monitor's one-deep address history assumes RL=1
  localparam int DC   = 2;
  localparam int MASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gemm_tile_sequencer_if #(.AddrWidth(AW), .SizeAddrWidth(SW)) ctl();

  gemm_tile_sequencer #(
    .AddrWidth(AW), .SizeAddrWidth(SW), .ReadLatency(RL), .DrainCycles(DC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctl   (ctl)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int mon_epoch = 0;
  int seen_epoch = 0;
  int unsigned q_a[$], q_b[$], q_c[$];
  int n_valid, n_clear, n_we, n_busy, n_done, n_err;
  int t_valid0, t_clear0, t_we0, t_busy0, t_done, t_err;
  int unsigned prev_a, prev_b;

  always @(negedge clk) begin
    if (mon_epoch != seen_epoch) begin
      seen_epoch = mon_epoch;
      q_a.delete(); q_b.delete(); q_c.delete();
      n_valid = 0; n_clear = 0; n_we = 0; n_busy = 0; n_done = 0; n_err = 0;
      t_valid0 = -1; t_clear0 = -1; t_we0 = -1; t_busy0 = -1; t_done = -1; t_err = -1;
    end
    if (ctl.mac_valid_o) begin
      q_a.push_back(prev_a);
      q_b.push_back(prev_b);
      n_valid++;
      if (t_valid0 < 0) t_valid0 = cyc;
    end
    if (ctl.mac_clear_o) begin
      n_clear++;
      if (t_clear0 < 0) t_clear0 = cyc;
    end
    if (ctl.sram_c_we_o) begin
      q_c.push_back(int'(ctl.sram_c_addr_o));
      n_we++;
      if (t_we0 < 0) t_we0 = cyc;
    end
    if (ctl.busy_o) begin
      n_busy++;
      if (t_busy0 < 0) t_busy0 = cyc;
    end
    if (ctl.done_o) begin
      n_done++;
      t_done = cyc;
    end
    if (ctl.err_o) begin
      n_err++;
      t_err = cyc;
    end
    prev_a = int'(ctl.sram_a_addr_o);
    prev_b = int'(ctl.sram_b_addr_o);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_job(input int m, input int k, input int n,
                         input int ab, input int bb, input int cb);
    ctl.M_size_i = SW'(m);
    ctl.K_size_i = SW'(k);
    ctl.N_size_i = SW'(n);
    ctl.a_base_i = AW'(ab);
    ctl.b_base_i = AW'(bb);
    ctl.c_base_i = AW'(cb);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ctl.done_o) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_case(input string tag, input int m, input int k, input int n,
                          input int ab, input int bb, input int cb);
    int s;
    int idx;
    int unsigned got;
    mon_epoch++;
    s = cyc;
    set_job(m, k, n, ab, bb, cb);
    ctl.start_i = 1'b1;
    @(posedge clk); #1;
    ctl.start_i = 1'b0;
    wait_done(tag, m * n * (k + RL + DC + 1) + 10);
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_t_busy0"},  64'(t_busy0),  64'(s + 1));
    check_eq({tag, "_t_valid0"}, 64'(t_valid0), 64'(s + 1 + RL));
    check_eq({tag, "_t_clear0"}, 64'(t_clear0), 64'(s + 1 + RL));
    check_eq({tag, "_t_we0"},    64'(t_we0),    64'(s + 1 + k + RL + DC));
    check_eq({tag, "_t_done"},   64'(t_done),   64'(s + m * n * (k + RL + DC + 1) + 1));
    check_eq({tag, "_n_busy"},   64'(n_busy),   64'(m * n * (k + RL + DC + 1) + 1));
    check_eq({tag, "_n_valid"},  64'(n_valid),  64'(m * n * k));
    check_eq({tag, "_n_clear"},  64'(n_clear),  64'(m * n));
    check_eq({tag, "_n_we"},     64'(n_we),     64'(m * n));
    check_eq({tag, "_n_done"},   64'(n_done),   64'd1);
    check_eq({tag, "_n_err"},    64'(n_err),    64'd0);
    idx = 0;
    for (int mi = 0; mi < m; mi++) begin
      for (int ni = 0; ni < n; ni++) begin
        got = (mi * n + ni < q_c.size()) ? q_c[mi * n + ni] : 32'hDEADBEEF;
        check_eq($sformatf("%s_c%0d", tag, mi * n + ni), 64'(got), 64'((cb + mi * n + ni) & MASK));
        for (int ki = 0; ki < k; ki++) begin
          got = (idx < q_a.size()) ? q_a[idx] : 32'hDEADBEEF;
          check_eq($sformatf("%s_a%0d", tag, idx), 64'(got), 64'((ab + mi * k + ki) & MASK));
          got = (idx < q_b.size()) ? q_b[idx] : 32'hDEADBEEF;
          check_eq($sformatf("%s_b%0d", tag, idx), 64'(got), 64'((bb + ni * k + ki) & MASK));
          idx++;
        end
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ctl.sram_a_addr_o, ctl.sram_b_addr_o, ctl.sram_c_addr_o, ctl.sram_c_we_o,
                ctl.mac_valid_o, ctl.mac_clear_o, ctl.busy_o, ctl.done_o, ctl.err_o});
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int s;
    int d;
    ctl.start_i = 1'b0;
    set_job(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;

    // 1x1x1 from base 0: ISSUE s+1, valid s+2, write s+5, done s+6
    run_case("unit", 1, 1, 1, 0, 0, 0);

    // 2x3x2 relocated bases
    run_case("m2k3n2", 2, 3, 2, 100, 200, 300);

    // A address wrap past 4095
    run_case("wrap", 1, 4, 1, 4094, 10, 4095);

    // zero K: err+done one cycle after start, nothing else
    mon_epoch++;
    s = cyc;
    set_job(2, 0, 2, 1, 2, 3);
    ctl.start_i = 1'b1;
    @(posedge clk); #1;
    ctl.start_i = 1'b0;
    @(negedge clk);
    check_eq("zero_err_pulse",  64'(ctl.err_o),  64'd1);
    check_eq("zero_done_pulse", 64'(ctl.done_o), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("zero_t_err", 64'(t_err),  64'(s + 1));
    check_eq("zero_n_err", 64'(n_err),  64'd1);
    check_eq("zero_n_done", 64'(n_done), 64'd1);
    check_eq("zero_n_we",  64'(n_we),   64'd0);
    check_eq("zero_n_busy", 64'(n_busy), 64'd0);

    // start held high: one run, then next run starts right after IDLE
    mon_epoch++;
    set_job(2, 2, 2, 10, 20, 30);
    ctl.start_i = 1'b1;
    @(posedge clk); #1;
    wait_done("hold1", 200);
    d = cyc;
    check_eq("hold1_n_we",    64'(n_we),    64'd4);
    check_eq("hold1_n_clear", 64'(n_clear), 64'd4);
    @(posedge clk); #1;
    mon_epoch++;
    @(posedge clk); #1;
    ctl.start_i = 1'b0;
    wait_done("hold2", 200);
    repeat (4) @(posedge clk);
    #1;
    check_eq("hold2_t_busy0", 64'(t_busy0), 64'(d + 2));
    check_eq("hold2_n_we",    64'(n_we),    64'd4);
    check_eq("hold2_n_done",  64'(n_done),  64'd1);

    // reset during the second tile's ISSUE of a 1x3x2 run
    mon_epoch++;
    set_job(1, 3, 2, 0, 50, 60);
    ctl.start_i = 1'b1;
    @(posedge clk); #1;
    ctl.start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("rst_mid_busy", 64'(ctl.busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outputs", all_outs(), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("rst_mid_n_we",  64'(n_we),  64'd1);
    check_eq("rst_mid_c0",    64'((q_c.size() > 0) ? q_c[0] : 32'hDEADBEEF), 64'd60);
    check_eq("rst_mid_n_done", 64'(n_done), 64'd0);

    run_case("post_rst", 1, 1, 1, 7, 8, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
